// File: rtl/stroke_painter.sv
// rtl/stroke_painter.sv - square-brush stroke rasteriser with clipping; optional eraser via STROKE_PAINTER_ERASER_EN
module stroke_painter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480
) (
`ifdef STROKE_PAINTER_ERASER_EN
    input  logic        erase_in,
`endif
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        nf_in,
    input  logic        draw_in,
    input  logic [9:0]  cursor_loc_x,
    input  logic [8:0]  cursor_loc_y,
    input  logic [3:0]  cursor_color,
    input  logic [2:0]  stroke_width,
    output logic [18:0] fb_addr_out,
    output logic [3:0]  fb_data_out,
    output logic        fb_we_out,
    output logic        busy_out,
    output logic        done_out
);

    typedef enum logic [1:0] {IDLE, PAINT, DONE} state_t;

    state_t      state, state_nx;
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [3:0]  color;
    logic [2:0]  wm1;
    logic [2:0]  dx, dy, dx_nx, dy_nx;
    logic [9:0]  bx;
    logic [8:0]  by;
    logic [2:0]  ox, oy;
    logic [10:0] px;
    logic [9:0]  py;
    logic        latch, pos_ld, busy_nx, done_nx, in_range;
    logic [18:0] addr_nx;
    logic [3:0]  data_nx;
`ifdef STROKE_PAINTER_ERASER_EN
    logic        erase_q;
`endif

    // The position that will be on the outputs next cycle is formed here, so
    // the first position leaves on the very edge that accepts the trigger.
    always_comb begin
        state_nx = state;
        dx_nx    = dx;
        dy_nx    = dy;
        bx       = x0;
        by       = y0;
        ox       = dx;
        oy       = dy;
        latch    = 1'b0;
        pos_ld   = 1'b0;
        busy_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (nf_in && draw_in) begin
                    state_nx = PAINT;
                    latch    = 1'b1;
                    pos_ld   = 1'b1;
                    busy_nx  = 1'b1;
                    dx_nx    = 3'd0;
                    dy_nx    = 3'd0;
                    bx       = cursor_loc_x;
                    by       = cursor_loc_y;
                    ox       = 3'd0;
                    oy       = 3'd0;
                end
            end
            PAINT: begin
                if (dx == wm1 && dy == wm1) begin
                    state_nx = DONE;
                    done_nx  = 1'b1;
                    dx_nx    = 3'd0;
                    dy_nx    = 3'd0;
                end else begin
                    pos_ld  = 1'b1;
                    busy_nx = 1'b1;
                    if (dx == wm1) begin
                        dx_nx = 3'd0;
                        dy_nx = dy + 3'd1;
                    end else begin
                        dx_nx = dx + 3'd1;
                    end
                    ox = dx_nx;
                    oy = dy_nx;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        px       = {1'b0, bx} + {8'd0, ox};
        py       = {1'b0, by} + {7'd0, oy};
        in_range = (32'(px) < H_RES) && (32'(py) < V_RES);
        addr_nx  = 19'(py) * 19'(H_RES) + 19'(px);
`ifdef STROKE_PAINTER_ERASER_EN
        if (latch) data_nx = erase_in ? 4'h0 : cursor_color;
        else       data_nx = erase_q  ? 4'h0 : color;
`else
        data_nx = latch ? cursor_color : color;
`endif
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state       <= IDLE;
            x0          <= '0;
            y0          <= '0;
            color       <= '0;
            wm1         <= '0;
            dx          <= '0;
            dy          <= '0;
            fb_addr_out <= '0;
            fb_data_out <= '0;
            fb_we_out   <= 1'b0;
            busy_out    <= 1'b0;
            done_out    <= 1'b0;
`ifdef STROKE_PAINTER_ERASER_EN
            erase_q     <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            dx        <= dx_nx;
            dy        <= dy_nx;
            busy_out  <= busy_nx;
            done_out  <= done_nx;
            fb_we_out <= pos_ld && in_range;
            if (latch) begin
                x0    <= cursor_loc_x;
                y0    <= cursor_loc_y;
                color <= cursor_color;
                wm1   <= stroke_width;
`ifdef STROKE_PAINTER_ERASER_EN
                erase_q <= erase_in;
`endif
            end
            if (pos_ld) begin
                fb_addr_out <= addr_nx;
                fb_data_out <= data_nx;
            end
        end
    end

endmodule

// File: doc/stroke_painter.md
STROKE_PAINTER -- requirements
Module: stroke_painter

Interface
REQ-001 SHALL have port clk_in, input, 1, system clock; all logic is single-clock, rising edge.
REQ-002 SHALL have port rst_n_in, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port nf_in, input, 1, new-frame strobe, one cycle wide.
REQ-004 SHALL have port draw_in, input, 1, pen-down level; painting is enabled only while high.
REQ-005 SHALL have port cursor_loc_x, input, 10, cursor column (0..639 valid).
REQ-006 SHALL have port cursor_loc_y, input, 9, cursor row (0..479 valid).
REQ-007 SHALL have port cursor_color, input, 4, pen colour index.
REQ-008 SHALL have port stroke_width, input, 3, brush size code.
REQ-009 SHALL have port fb_addr_out, output, 19, framebuffer write address.
REQ-010 SHALL have port fb_data_out, output, 4, framebuffer write data.
REQ-011 SHALL have port fb_we_out, output, 1, framebuffer write enable.
REQ-012 SHALL have port busy_out, output, 1, high while a stroke is in progress.
REQ-013 SHALL have port done_out, output, 1, one-cycle pulse when a stroke completes.
REQ-014 SHALL have parameter H_RES, default 640, canvas width in pixels.
REQ-015 SHALL have parameter V_RES, default 480, canvas height in pixels.

Function
REQ-016 SHALL implement the FSM states IDLE, PAINT and DONE.
REQ-017 Trigger SHALL be nf_in=1 AND draw_in=1 sampled in IDLE at edge k; this latches x0, y0, colour and N = stroke_width+1 (1..8), then enters PAINT.
REQ-018 PAINT SHALL visit N*N positions row-major (dy outer, dx inner, each 0..N-1), exactly one position per cycle; position i is presented in cycle k+1+i.
REQ-019 Per position, px=x0+dx and py=y0+dy SHALL be computed at 11/10 bits, so there is no wrap-around.
REQ-020 For each position, fb_we_out SHALL be 1 only if px<H_RES and py<V_RES; clipped positions still consume their cycle, with fb_we_out=0.
REQ-021 fb_addr_out SHALL equal py*H_RES+px, truncated to 19 bits; fb_data_out SHALL equal the latched colour; all three are registered outputs.
REQ-022 busy_out SHALL be 1 for cycles k+1 .. k+N*N inclusive.
REQ-023 In cycle k+1+N*N the FSM SHALL be in DONE, with done_out=1, busy_out=0 and fb_we_out=0; it then returns to IDLE.
REQ-024 Any nf_in pulse while in PAINT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-025 Input changes on cursor_loc_x, cursor_loc_y, cursor_color or stroke_width during PAINT SHALL NOT affect the stroke in progress.
REQ-026 nf_in=1 with draw_in=0 in IDLE SHALL produce no activity.
REQ-027 In IDLE, fb_we_out SHALL be 0; fb_addr_out and fb_data_out hold their last values.

Reset
REQ-028 rst_n_in=0 at any edge SHALL force IDLE and set fb_addr_out=0, fb_data_out=0, fb_we_out=0, busy_out=0, done_out=0 and all counters to 0.
REQ-029 Reset mid-stroke SHALL abort the stroke; no further writes occur and no done_out pulse is produced.
REQ-030 A trigger coincident with rst_n_in=0 SHALL be ignored.

Configuration
REQ-031 The macro STROKE_PAINTER_ERASER_EN, when defined, SHALL add an input port erase_in, 1 bit.
REQ-032 With STROKE_PAINTER_ERASER_EN defined, erase_in is latched at the trigger; if it is 1, fb_data_out SHALL be 4'h0 for the whole stroke.
REQ-033 Without STROKE_PAINTER_ERASER_EN, the erase_in port SHALL NOT exist and the latched cursor_color is always written.

Verification
REQ-034 Minimal stroke: reset, then trigger with x=100, y=50, colour=4'hA, width=0 -> one write addr=32100, data=A; busy_out high 1 cycle; done_out pulses in the next cycle.
REQ-035 Full brush: trigger with x=10, y=20, width=1 -> 4 writes, addrs 12810, 12811, 13450, 13451 in order; busy_out high 4 cycles.
REQ-036 Clipping: trigger with x=638, y=478, width=3 -> 16 busy cycles, writes only at (638,478), (639,478), (638,479), (639,479); max addr 307199.
REQ-037 Ignored triggers: nf_in during PAINT, and nf_in with draw_in=0 -> no extra writes; done_out count equals the accepted trigger count.
REQ-038 Abort: reset asserted in cycle 5 of a width=7 stroke -> all outputs 0 on the next edge; no done_out pulse.
REQ-039 Eraser: with STROKE_PAINTER_ERASER_EN defined, erase_in=1, colour=4'hF -> every write carries data 4'h0.
